// File: rtl/reg_bus_pkg.sv
// Shared definitions for the user-logic register bus: sequencer state encoding
// and default bus geometry.
package reg_bus_pkg;

    localparam int unsigned DefAddrWidth = 12;
    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefRdWait    = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RWAIT  = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/reg_bus_arb2_if.sv
// One requester channel of the register-bus arbiter: level request with
// qualifiers, one-cycle ack and held read data.
interface reg_bus_arb2_if
    import reg_bus_pkg::*;
#(
    parameter int unsigned CPU_ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned CPU_DATA_WIDTH = DefDataWidth
) ();

    logic                      req;
    logic                      wr;
    logic [CPU_ADDR_WIDTH-1:0] addr;
    logic [CPU_DATA_WIDTH-1:0] wdata;
    logic                      ack;
    logic [CPU_DATA_WIDTH-1:0] rdata;

    modport master (
        output req, wr, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, wr, addr, wdata,
        output ack, rdata
    );

endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker; on a tie the requester that was
// not served last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       enable,
    output logic       grant_vld,
    output logic       grant_idx
);

    always_comb begin
        grant_vld = enable && (req != 2'b00);
        grant_idx = 1'b0;
        case (req)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last_grant;
            default: grant_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/reg_bus_arb2.sv
// Two-master round-robin arbiter and access sequencer for the register bus:
// single-cycle strobes, held address/data, read-latency wait and one-cycle ack.
module reg_bus_arb2
    import reg_bus_pkg::*;
#(
    parameter int unsigned CPU_ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned CPU_DATA_WIDTH = DefDataWidth,
    parameter int unsigned RD_WAIT        = DefRdWait
) (
    input  logic                      clks,
    input  logic                      reset,
    reg_bus_arb2_if.slave             m0,
    reg_bus_arb2_if.slave             m1,
    output logic                      cpu_wr,
    output logic                      cpu_rd,
    output logic [CPU_ADDR_WIDTH-1:0] cpu_wr_addr,
    output logic [CPU_DATA_WIDTH-1:0] cpu_data_in,
    input  logic [CPU_DATA_WIDTH-1:0] cpu_data_out,
    output logic                      busy,
    output logic                      last_grant
);

    localparam int unsigned CntW = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;

    state_e                    state_q, state_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic                      last_q, last_d;
    logic                      wr_q, wr_d;
    logic                      cpu_wr_q, cpu_wr_d;
    logic                      cpu_rd_q, cpu_rd_d;
    logic [CPU_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CPU_DATA_WIDTH-1:0] data_q, data_d;
    logic [1:0]                ack_q, ack_d;
    logic [CPU_DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [CPU_DATA_WIDTH-1:0] rdata1_q, rdata1_d;
    logic                      busy_q, busy_d;
    logic                      gnt_vld, gnt_idx;

    rr_arb2 u_rr_arb2 (
        .req        ({m1.req, m0.req}),
        .last_grant (last_q),
        .enable     (state_q == IDLE),
        .grant_vld  (gnt_vld),
        .grant_idx  (gnt_idx)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        wr_d     = wr_q;
        cpu_wr_d = 1'b0;
        cpu_rd_d = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        ack_d    = 2'b00;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    last_d   = gnt_idx;
                    wr_d     = gnt_idx ? m1.wr    : m0.wr;
                    addr_d   = gnt_idx ? m1.addr  : m0.addr;
                    data_d   = gnt_idx ? m1.wdata : m0.wdata;
                    cpu_wr_d = wr_d;
                    cpu_rd_d = ~wr_d;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                if (wr_q) begin
                    ack_d[last_q] = 1'b1;
                    state_d       = DONE;
                end else begin
                    cnt_d   = CntW'(RD_WAIT - 1);
                    state_d = RWAIT;
                end
            end
            RWAIT: begin
                // cpu_data_out lags the address by one cycle; last wait cycle samples it
                if (cnt_q == '0) begin
                    if (last_q) rdata1_d = cpu_data_out;
                    else        rdata0_d = cpu_data_out;
                    ack_d[last_q] = 1'b1;
                    state_d       = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clks or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            wr_q     <= 1'b0;
            cpu_wr_q <= 1'b0;
            cpu_rd_q <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            ack_q    <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            wr_q     <= wr_d;
            cpu_wr_q <= cpu_wr_d;
            cpu_rd_q <= cpu_rd_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            ack_q    <= ack_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            busy_q   <= busy_d;
        end
    end

    assign cpu_wr      = cpu_wr_q;
    assign cpu_rd      = cpu_rd_q;
    assign cpu_wr_addr = addr_q;
    assign cpu_data_in = data_q;
    assign busy        = busy_q;
    assign last_grant  = last_q;
    assign m0.ack      = ack_q[0];
    assign m1.ack      = ack_q[1];
    assign m0.rdata    = rdata0_q;
    assign m1.rdata    = rdata1_q;

endmodule

// File: tb/tb_reg_bus_arb2.sv
// Directed bench for reg_bus_arb2: default build plus an RD_WAIT=1 build, each
// driving a small registered-read register-file model.
module tb_reg_bus_arb2;
    import reg_bus_pkg::*;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;

    logic clks  = 1'b0;
    logic reset = 1'b1;
    always #5 clks = ~clks;

    reg_bus_arb2_if #(.CPU_ADDR_WIDTH(AW), .CPU_DATA_WIDTH(DW)) m0_if ();
    reg_bus_arb2_if #(.CPU_ADDR_WIDTH(AW), .CPU_DATA_WIDTH(DW)) m1_if ();
    reg_bus_arb2_if #(.CPU_ADDR_WIDTH(AW), .CPU_DATA_WIDTH(DW)) n0_if ();
    reg_bus_arb2_if #(.CPU_ADDR_WIDTH(AW), .CPU_DATA_WIDTH(DW)) n1_if ();

    logic          cpu_wr, cpu_rd, busy, last_grant;
    logic [AW-1:0] cpu_wr_addr;
    logic [DW-1:0] cpu_data_in, cpu_data_out;
    logic          cpu_wr_b, cpu_rd_b, busy_b, last_grant_b;
    logic [AW-1:0] cpu_wr_addr_b;
    logic [DW-1:0] cpu_data_in_b, cpu_data_out_b;

    reg_bus_arb2 #(.CPU_ADDR_WIDTH(AW), .CPU_DATA_WIDTH(DW), .RD_WAIT(2)) dut (
        .clks         (clks),
        .reset        (reset),
        .m0           (m0_if),
        .m1           (m1_if),
        .cpu_wr       (cpu_wr),
        .cpu_rd       (cpu_rd),
        .cpu_wr_addr  (cpu_wr_addr),
        .cpu_data_in  (cpu_data_in),
        .cpu_data_out (cpu_data_out),
        .busy         (busy),
        .last_grant   (last_grant)
    );

    reg_bus_arb2 #(.CPU_ADDR_WIDTH(AW), .CPU_DATA_WIDTH(DW), .RD_WAIT(1)) dut_b (
        .clks         (clks),
        .reset        (reset),
        .m0           (n0_if),
        .m1           (n1_if),
        .cpu_wr       (cpu_wr_b),
        .cpu_rd       (cpu_rd_b),
        .cpu_wr_addr  (cpu_wr_addr_b),
        .cpu_data_in  (cpu_data_in_b),
        .cpu_data_out (cpu_data_out_b),
        .busy         (busy_b),
        .last_grant   (last_grant_b)
    );

    // Register file: registered read; address 4 returns regs[2] + regs[3]
    logic [DW-1:0] regs [16] = '{0: 32'h2017_1108, 1: 32'h00D1_0006, default: '0};

    function automatic logic [DW-1:0] rf_read(input logic [AW-1:0] a);
        if (a == 12'd4) return regs[2] + regs[3];
        return regs[a[3:0]];
    endfunction

    always @(posedge clks) begin
        cpu_data_out   <= rf_read(cpu_wr_addr);
        cpu_data_out_b <= rf_read(cpu_wr_addr_b);
        if (cpu_wr) regs[cpu_wr_addr[3:0]] <= cpu_data_in;
    end

    int overlap_cnt = 0;
    always @(negedge clks) begin
        if ((cpu_wr && cpu_rd) || (cpu_wr_b && cpu_rd_b)) overlap_cnt++;
    end

    int checks = 0;
    int passes = 0;

    function automatic logic [4:0] obs_a();
        return {cpu_wr, cpu_rd, m0_if.ack, m1_if.ack, busy};
    endfunction

    function automatic logic [4:0] obs_b();
        return {cpu_wr_b, cpu_rd_b, n0_if.ack, n1_if.ack, busy_b};
    endfunction

    task automatic tick();
        @(posedge clks);
        #1;
    endtask

    task automatic drv0(input logic r, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
        m0_if.req = r; m0_if.wr = w; m0_if.addr = a; m0_if.wdata = d;
    endtask

    task automatic drv1(input logic r, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
        m1_if.req = r; m1_if.wr = w; m1_if.addr = a; m1_if.wdata = d;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if (obs_a() !== 5'b00000) $display("FAIL reset_strobes got %b want 00000", obs_a());
        else passes++;
        checks++;
        if (cpu_wr_addr !== '0 || cpu_data_in !== '0)
            $display("FAIL reset_bus got addr=%h data=%h want 0/0", cpu_wr_addr, cpu_data_in);
        else passes++;
        checks++;
        if (m0_if.rdata !== '0 || m1_if.rdata !== '0)
            $display("FAIL reset_rdata got %h/%h want 0/0", m0_if.rdata, m1_if.rdata);
        else passes++;
        checks++;
        if (last_grant !== 1'b1) $display("FAIL reset_last_grant got %b want 1", last_grant);
        else passes++;
        reset = 1'b0;
        tick();
        checks++;
        if (obs_a() !== 5'b00000 || obs_b() !== 5'b00000)
            $display("FAIL post_reset_idle got %b/%b want 00000", obs_a(), obs_b());
        else passes++;
    endtask

    // Both masters held on writes for four transactions
    task automatic test_alternation();
        int   k, ph;
        logic mst;
        logic [4:0] want;
        drv0(1'b1, 1'b1, 12'd5, 32'h0000_00A5);
        drv1(1'b1, 1'b1, 12'd6, 32'h0000_00B6);
        for (int c = 1; c <= 13; c++) begin
            tick();
            k    = (c - 1) / 3;
            ph   = (c - 1) % 3;
            mst  = k[0];
            want = 5'b00000;
            if (k < 4) begin
                if (ph == 0)      want = 5'b10001;
                else if (ph == 1) want = mst ? 5'b00011 : 5'b00101;
            end
            checks++;
            if (obs_a() !== want) $display("FAIL alt_trace c=%0d got %b want %b", c, obs_a(), want);
            else passes++;
            if (k < 4 && ph == 0) begin
                checks++;
                if (cpu_wr_addr !== (mst ? 12'd6 : 12'd5) || last_grant !== mst)
                    $display("FAIL alt_grant c=%0d got addr=%0d lg=%b want master %b",
                             c, cpu_wr_addr, last_grant, mst);
                else passes++;
            end
            if (c == 12) begin
                drv0(1'b0, 1'b0, '0, '0);
                drv1(1'b0, 1'b0, '0, '0);
            end
        end
        checks++;
        if (overlap_cnt !== 0) $display("FAIL alt_overlap got %0d want 0", overlap_cnt);
        else passes++;
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_tbl [1:17];
        exp_tbl = '{5'b10001, 5'b00101, 5'b00000, 5'b01001, 5'b00001, 5'b00001, 5'b00011,
                    5'b00000, 5'b10001, 5'b00101, 5'b00000, 5'b01001, 5'b00001, 5'b00001,
                    5'b00011, 5'b00000, 5'b00000};
        drv0(1'b1, 1'b1, 12'd7, 32'h0000_0077);
        drv1(1'b1, 1'b0, 12'd5, '0);
        for (int c = 1; c <= 17; c++) begin
            tick();
            checks++;
            if (obs_a() !== exp_tbl[c])
                $display("FAIL b2b_trace c=%0d got %b want %b", c, obs_a(), exp_tbl[c]);
            else passes++;
            case (c)
                1, 9: begin
                    checks++;
                    if (cpu_wr_addr !== (c == 1 ? 12'd7 : 12'd8) ||
                        cpu_data_in !== (c == 1 ? 32'h77 : 32'h88))
                        $display("FAIL b2b_wr c=%0d got %0d/%h", c, cpu_wr_addr, cpu_data_in);
                    else passes++;
                end
                4, 12: begin
                    checks++;
                    if (cpu_wr_addr !== (c == 4 ? 12'd5 : 12'd7))
                        $display("FAIL b2b_rd_addr c=%0d got %0d", c, cpu_wr_addr);
                    else passes++;
                end
                7, 15: begin
                    checks++;
                    if (m1_if.rdata !== (c == 7 ? 32'hA5 : 32'h77))
                        $display("FAIL b2b_rdata c=%0d got %h", c, m1_if.rdata);
                    else passes++;
                end
                default: ;
            endcase
            if (c == 3)  drv0(1'b1, 1'b1, 12'd8, 32'h0000_0088);
            if (c == 8)  drv1(1'b1, 1'b0, 12'd7, '0);
            if (c == 11) drv0(1'b0, 1'b0, '0, '0);
            if (c == 16) drv1(1'b0, 1'b0, '0, '0);
        end
        checks++;
        if (overlap_cnt !== 0) $display("FAIL b2b_overlap got %0d want 0", overlap_cnt);
        else passes++;
    endtask

    task automatic test_m0_read();
        logic [4:0] exp_tbl [1:6];
        exp_tbl = '{5'b01001, 5'b00001, 5'b00001, 5'b00101, 5'b00000, 5'b00000};
        drv0(1'b1, 1'b0, 12'd0, '0);
        for (int c = 1; c <= 6; c++) begin
            tick();
            checks++;
            if (obs_a() !== exp_tbl[c])
                $display("FAIL rd0_trace c=%0d got %b want %b", c, obs_a(), exp_tbl[c]);
            else passes++;
            if (c == 4) begin
                checks++;
                if (m0_if.rdata !== 32'h2017_1108 || m1_if.rdata !== 32'h77)
                    $display("FAIL rd0_data got %h/%h want 20171108/00000077",
                             m0_if.rdata, m1_if.rdata);
                else passes++;
            end
            if (c == 5) drv0(1'b0, 1'b0, '0, '0);
        end
    endtask

    task automatic test_writes_then_read();
        logic [4:0] exp_tbl [1:11];
        exp_tbl = '{5'b10001, 5'b00011, 5'b00000, 5'b10001, 5'b00011, 5'b00000, 5'b01001,
                    5'b00001, 5'b00001, 5'b00101, 5'b00000};
        drv1(1'b1, 1'b1, 12'd2, 32'h0000_0005);
        for (int c = 1; c <= 11; c++) begin
            tick();
            checks++;
            if (obs_a() !== exp_tbl[c])
                $display("FAIL wwr_trace c=%0d got %b want %b", c, obs_a(), exp_tbl[c]);
            else passes++;
            if (c == 1 || c == 4) begin
                checks++;
                if (cpu_wr_addr !== (c == 1 ? 12'd2 : 12'd3) ||
                    cpu_data_in !== (c == 1 ? 32'd5 : 32'd7))
                    $display("FAIL wwr_wr c=%0d got %0d/%h", c, cpu_wr_addr, cpu_data_in);
                else passes++;
            end
            if (c == 10) begin
                checks++;
                if (m0_if.rdata !== 32'h0000_000C || m1_if.rdata !== 32'h77)
                    $display("FAIL wwr_sum got %h/%h want 0000000c/00000077",
                             m0_if.rdata, m1_if.rdata);
                else passes++;
            end
            if (c == 3) drv1(1'b1, 1'b1, 12'd3, 32'h0000_0007);
            if (c == 6) begin
                drv1(1'b0, 1'b0, '0, '0);
                drv0(1'b1, 1'b0, 12'd4, '0);
            end
            if (c == 11) drv0(1'b0, 1'b0, '0, '0);
        end
    endtask

    task automatic test_reset_mid_txn();
        drv0(1'b1, 1'b0, 12'd0, '0);
        tick();
        tick();
        checks++;
        if (obs_a() !== 5'b00001) $display("FAIL rst_rwait got %b want 00001", obs_a());
        else passes++;
        reset = 1'b1;
        #1;
        checks++;
        if (obs_a() !== 5'b00000 || m0_if.rdata !== '0 || cpu_wr_addr !== '0 ||
            last_grant !== 1'b1)
            $display("FAIL rst_async got %b rd=%h addr=%h lg=%b", obs_a(), m0_if.rdata,
                     cpu_wr_addr, last_grant);
        else passes++;
        drv0(1'b0, 1'b0, '0, '0);
        tick();
        tick();
        reset = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            checks++;
            if (obs_a() !== 5'b00000) $display("FAIL rst_quiet c=%0d got %b", c, obs_a());
            else passes++;
        end
        drv1(1'b1, 1'b1, 12'd9, 32'h0000_0099);
        tick();
        checks++;
        if (obs_a() !== 5'b10001 || cpu_wr_addr !== 12'd9 || cpu_data_in !== 32'h99)
            $display("FAIL rst_new_wr got %b %0d/%h", obs_a(), cpu_wr_addr, cpu_data_in);
        else passes++;
        tick();
        checks++;
        if (obs_a() !== 5'b00011) $display("FAIL rst_new_ack got %b want 00011", obs_a());
        else passes++;
        tick();
        drv1(1'b0, 1'b0, '0, '0);
        tick();
        checks++;
        if (obs_a() !== 5'b00000) $display("FAIL rst_new_idle got %b want 00000", obs_a());
        else passes++;
    endtask

    task automatic test_rd_wait1();
        logic [4:0] exp_tbl [1:5];
        exp_tbl = '{5'b01001, 5'b00001, 5'b00101, 5'b00000, 5'b00000};
        n0_if.req = 1'b1; n0_if.wr = 1'b0; n0_if.addr = 12'd1; n0_if.wdata = '0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            checks++;
            if (obs_b() !== exp_tbl[c])
                $display("FAIL rw1_trace c=%0d got %b want %b", c, obs_b(), exp_tbl[c]);
            else passes++;
            if (c == 3) begin
                checks++;
                if (n0_if.rdata !== 32'h00D1_0006)
                    $display("FAIL rw1_data got %h want 00d10006", n0_if.rdata);
                else passes++;
            end
            if (c == 4) n0_if.req = 1'b0;
        end
    endtask

    initial begin
        drv0(1'b0, 1'b0, '0, '0);
        drv1(1'b0, 1'b0, '0, '0);
        n0_if.req = 1'b0; n0_if.wr = 1'b0; n0_if.addr = '0; n0_if.wdata = '0;
        n1_if.req = 1'b0; n1_if.wr = 1'b0; n1_if.addr = '0; n1_if.wdata = '0;
        test_reset();
        test_alternation();
        test_back_to_back();
        test_m0_read();
        test_writes_then_read();
        test_reset_mid_txn();
        test_rd_wait1();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
